// File: rtl/bit_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bit_stream_pkg
//  Purpose  : Shared types for the bit-stream lock detector: FSM state
//             encoding, lock-polarity mode encodings and a helper that
//             decides whether a run polarity may be locked under a mode.
//  Revision : 1.0 - initial release
// ============================================================================
package bit_stream_pkg;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_LOCK = 2'd1,
        ST_MISS = 2'd2
    } state_e;

    localparam logic [1:0] c_MODE_ANY     = 2'b00;
    localparam logic [1:0] c_MODE_ONES    = 2'b01;
    localparam logic [1:0] c_MODE_ZEROS   = 2'b10;
    localparam logic [1:0] c_MODE_ANY_ALT = 2'b11;

    // Returns 1 when a run of polarity pol may be locked under mode.
    function automatic logic mode_permits(input logic [1:0] mode, input logic pol);
        logic ok;
        case (mode)
            c_MODE_ONES:  ok = pol;
            c_MODE_ZEROS: ok = ~pol;
            default:      ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Up-counter saturating at LIMIT with clear and load.
//             Priority: rst > hold (en_i=0) > clr_i > load_i > inc_i.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             en_i              - advance qualifier; all else held when 0
//             clr_i             - clear to zero
//             load_i/load_val_i - load a value
//             inc_i             - increment, stops at LIMIT
//             cnt_o             - current count
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 3,
    parameter int LIMIT = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] c_LIMIT = WIDTH'(LIMIT);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && (cnt_q != c_LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/bit_stream_lock.sv
`default_nettype none
// ============================================================================
//  Module   : bit_stream_lock
//  Purpose  : Detects RUN_LEN consecutive equal bits on a serial stream and
//             holds lock until MISS_LEN consecutive mismatching bits arrive.
//             A polarity filter (mode) gates acquisition only.
//  Ports    : clk, rst   - clock, synchronous active-high reset
//             en         - bit-valid qualifier
//             din        - serial data bit
//             mode       - 00/11 any, 01 ones only, 10 zeros only
//             lock       - registered lock indication
//             lock_val   - polarity of the current / most recent run
//             run_cnt    - current run length (CNT_W bits)
//             state      - debug copy of FSM state
//             stats_clr, lock_events - only with BIT_STREAM_LOCK_STATS_EN
//  Options  : define BIT_STREAM_LOCK_STATS_EN to add a 16-bit saturating
//             count of acquisitions with a clear input.
//  Revision : 1.0 - initial release
// ============================================================================
module bit_stream_lock
    import bit_stream_pkg::*;
#(
    parameter int RUN_LEN  = 5,
    parameter int MISS_LEN = 1,
    localparam int CNT_W   = $clog2(RUN_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic [1:0]       mode,
    output logic             lock,
    output logic             lock_val,
    output logic [CNT_W-1:0] run_cnt,
    output logic [1:0]       state
`ifdef BIT_STREAM_LOCK_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [15:0]      lock_events
`endif
);

    localparam int MISS_W = $clog2(MISS_LEN + 1);

    state_e            state_q;
    state_e            state_d;
    logic              lock_val_q;
    logic              lock_val_d;
    logic              lock_q;
    logic [CNT_W-1:0]  run_cnt_q;
    logic [MISS_W-1:0] miss_cnt_q;

    logic              w_run_load;
    logic [CNT_W-1:0]  w_run_load_val;
    logic              w_run_inc;
    logic              w_miss_clr;
    logic              w_miss_load;
    logic              w_miss_inc;
    logic              w_match;

    assign w_match = (din == lock_val_q);

    always_comb begin
        state_d        = state_q;
        lock_val_d     = lock_val_q;
        w_run_load     = 1'b0;
        w_run_load_val = '0;
        w_run_inc      = 1'b0;
        w_miss_clr     = 1'b0;
        w_miss_load    = 1'b0;
        w_miss_inc     = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (w_match) begin
                    w_run_inc = 1'b1;
                    // This bit makes (or keeps) the run at RUN_LEN; a run
                    // held saturated by the mode filter locks as soon as the
                    // filter opens.
                    if ((run_cnt_q >= CNT_W'(RUN_LEN - 1)) && mode_permits(mode, lock_val_q)) begin
                        state_d = ST_LOCK;
                    end
                end else begin
                    lock_val_d     = din;
                    w_run_load     = 1'b1;
                    w_run_load_val = CNT_W'(1);
                end
            end
            ST_LOCK: begin
                if (!w_match) begin
                    if (MISS_LEN == 1) begin
                        state_d        = ST_HUNT;
                        lock_val_d     = din;
                        w_run_load     = 1'b1;
                        w_run_load_val = CNT_W'(1);
                    end else begin
                        state_d     = ST_MISS;
                        w_miss_load = 1'b1;
                    end
                end
            end
            ST_MISS: begin
                if (w_match) begin
                    state_d    = ST_LOCK;
                    w_miss_clr = 1'b1;
                end else if (miss_cnt_q >= MISS_W'(MISS_LEN - 1)) begin
                    // The misses already form a run of the opposite polarity.
                    state_d        = ST_HUNT;
                    lock_val_d     = ~lock_val_q;
                    w_run_load     = 1'b1;
                    w_run_load_val = CNT_W'(MISS_LEN);
                    w_miss_clr     = 1'b1;
                end else begin
                    w_miss_inc = 1'b1;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HUNT;
            lock_val_q <= 1'b0;
            lock_q     <= 1'b0;
        end else if (en) begin
            state_q    <= state_d;
            lock_val_q <= lock_val_d;
            lock_q     <= (state_d == ST_LOCK) || (state_d == ST_MISS);
        end
    end

    sat_counter #(
        .WIDTH (CNT_W),
        .LIMIT (RUN_LEN)
    ) u_run_cnt (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en),
        .clr_i      (1'b0),
        .load_i     (w_run_load),
        .load_val_i (w_run_load_val),
        .inc_i      (w_run_inc),
        .cnt_o      (run_cnt_q)
    );

    sat_counter #(
        .WIDTH (MISS_W),
        .LIMIT (MISS_LEN)
    ) u_miss_cnt (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en),
        .clr_i      (w_miss_clr),
        .load_i     (w_miss_load),
        .load_val_i (MISS_W'(1)),
        .inc_i      (w_miss_inc),
        .cnt_o      (miss_cnt_q)
    );

`ifdef BIT_STREAM_LOCK_STATS_EN
    logic        w_take;
    logic [15:0] lock_events_q;

    assign w_take = en && (state_q == ST_HUNT) && (state_d == ST_LOCK);

    // Clear is independent of en and wins over a same-edge acquisition.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_events_q <= 16'h0000;
        end else if (stats_clr) begin
            lock_events_q <= 16'h0000;
        end else if (w_take && (lock_events_q != 16'hFFFF)) begin
            lock_events_q <= lock_events_q + 16'h0001;
        end
    end

    assign lock_events = lock_events_q;
`endif

    assign lock     = lock_q;
    assign lock_val = lock_val_q;
    assign run_cnt  = run_cnt_q;
    assign state    = state_q;

endmodule
`default_nettype wire

// File: doc/bit_stream_lock.md
BIT_STREAM_LOCK -- requirements
Module: bit_stream_lock

Interface
REQ-001 The parameter RUN_LEN SHALL default to 5 and set the number of consecutive equal bits needed to acquire lock (legal range 2..255).
REQ-002 The parameter MISS_LEN SHALL default to 1 and set the number of consecutive mismatching bits that drop lock (legal range 1..RUN_LEN-1).
REQ-003 The clock and reset SHALL be one clock, `clk`, and a synchronous active-high reset, `rst`; this is already decided.
REQ-004 `clk`  in  1  rising-edge clock for all state.
REQ-005 `rst`  in  1  synchronous active-high reset, sampled on the rising edge of `clk`.
REQ-006 `en`  in  1  bit-valid qualifier; `din` is consumed only on edges where `en`=1.
REQ-007 `din`  in  1  serial data bit.
REQ-008 `mode`  in  2  lock polarity filter: 00 = any, 01 = ones only, 10 = zeros only, 11 = treated as 00.
REQ-009 `lock`  out  1  registered lock indication.
REQ-010 `lock_val`  out  1  polarity of the current or most recent run.
REQ-011 `run_cnt`  out  CNT_W  current run length; CNT_W = $clog2(RUN_LEN+1).
REQ-012 `state`  out  2  debug copy of the FSM state encoding.

Function
REQ-013 The block SHALL advance only on rising edges where `rst`=0 and `en`=1; on edges where `en`=0, every register SHALL hold its value.
REQ-014 The FSM SHALL have exactly three states: HUNT=2'd0, LOCK=2'd1 and MISS=2'd2; the value 2'd3 SHALL recover to HUNT on the next enabled edge.
REQ-015 In HUNT, when `din`==`lock_val`, `run_cnt` SHALL increment and saturate at RUN_LEN.
REQ-016 In HUNT, when `din`!=`lock_val`, `lock_val` SHALL take the value of `din` and `run_cnt` SHALL be set to 1.
REQ-017 The HUNT->LOCK transition SHALL occur on the enabled edge that makes the run length equal RUN_LEN, and only if `mode` permits that polarity.
- `lock` SHALL be 1 in the cycle immediately after that edge.
- The latency from the edge sampling the RUN_LEN-th bit to `lock`=1 SHALL be exactly one edge.
REQ-018 If `mode` forbids the polarity of the run, the FSM SHALL stay in HUNT with `run_cnt` saturated at RUN_LEN and `lock`=0.
- If `mode` changes to permit that polarity while the run continues, lock SHALL be taken on the next enabled edge with a matching `din`.
REQ-019 In LOCK, a bit matching `lock_val` SHALL keep the state and keep `run_cnt` at RUN_LEN.
REQ-020 In LOCK, a mismatching bit SHALL act as follows:
- with MISS_LEN=1: go to HUNT with `lock_val`=`din` and `run_cnt`=1;
- otherwise: go to MISS with the miss count set to 1.
REQ-021 In MISS, a bit matching `lock_val` SHALL return the FSM to LOCK and clear the miss count.
REQ-022 In MISS, the mismatching bit that brings the miss count to MISS_LEN SHALL send the FSM to HUNT with `lock_val` inverted and `run_cnt`=MISS_LEN.
REQ-023 `lock` SHALL be 1 in both LOCK and MISS, and 0 in HUNT.
REQ-024 `mode` SHALL be evaluated only on the HUNT->LOCK decision; changes to `mode` while in LOCK or MISS SHALL be ignored.

Reset
REQ-025 Reset SHALL set the following values, and SHALL take priority over `en`:
- `state`=HUNT, `lock`=0, `lock_val`=0, `run_cnt`=0;
- miss count=0 and `lock_events`=0.
REQ-026 Reset asserted mid-run or while locked SHALL clear all state on that edge, and the next run SHALL start from `run_cnt`=1.

Configuration
REQ-027 When the macro BIT_STREAM_LOCK_STATS_EN is defined, the block SHALL add output `lock_events` (16 bits) and input `stats_clr` (1 bit).
- `lock_events` SHALL increment on each HUNT->LOCK transition and saturate at 16'hFFFF.
- When `stats_clr`=1, `lock_events` SHALL clear to 0 regardless of `en`; a clear SHALL take priority over a simultaneous increment.
REQ-028 When BIT_STREAM_LOCK_STATS_EN is not defined, neither port nor counter logic SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-029 The state enum type and the `mode` encodings SHALL live in the package `bit_stream_pkg`.
REQ-030 The saturating run/miss counter SHALL be a single sub-module, `sat_counter`, parametrised by width and limit and instantiated twice.

Verification (RUN_LEN=5, MISS_LEN=2 unless stated)
REQ-031 The bench SHALL cover these directed scenarios:
- `din`=1 for 5 enabled edges with `mode`=00 -> `lock`=1 one edge after the 5th bit, `lock_val`=1, `run_cnt`=5.
- While locked on 1s, send `din`=0, 1, 0, 0 -> `state` goes MISS, LOCK, MISS, HUNT; `lock` falls after the 2nd consecutive 0, with `lock_val`=0 and `run_cnt`=2.
- `mode`=01 with 7 zeros -> `lock` stays 0 and `run_cnt`=5; switch `mode`=00 and send one more 0 -> `lock`=1 next edge.
- Toggle `en` 1/0 with `din`=1 (enabled bits only count) -> `lock` at the 5th enabled bit, independent of disabled cycles.
- Assert `rst` for 1 cycle while in MISS -> all outputs return to reset values on the next cycle.
- With MISS_LEN=1, lock on 5 zeros, then `din`=1 -> HUNT, `lock`=0, `run_cnt`=1; with stats enabled, 3 acquisitions -> `lock_events`=3, and `stats_clr` -> 0.
